// File: rtl/fifo_pkg.sv
// Shared constants, FSM state type and width helper for the read-side packer.
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 4;
    localparam int unsigned DEFAULT_PACK       = 4;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        FLUSHING = 2'd1,
        STALL    = 2'd2
    } state_e;

    // Width needed to count 0..pack entries inclusive.
    function automatic int unsigned cnt_width(input int unsigned pack);
        return $clog2(pack + 1);
    endfunction

endpackage

// File: rtl/fifo_nibble_packer_if.sv
// FIFO read side, flush request and packed-word output bundle.
interface fifo_nibble_packer_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned PACK       = DEFAULT_PACK
);

    localparam int unsigned CNT_W  = cnt_width(PACK);
    localparam int unsigned WORD_W = DATA_WIDTH * PACK;

    logic [DATA_WIDTH-1:0] FIFO_DATA;
    logic                  FIFO_EMPTY;
    logic                  FIFO_R_EN;
    logic                  FLUSH;
    logic [WORD_W-1:0]     OUT_DATA;
    logic [CNT_W-1:0]      OUT_NIBBLES;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic                  BUSY;

    // Packer side.
    modport master (
        input  FIFO_DATA,
        input  FIFO_EMPTY,
        input  FLUSH,
        input  OUT_READY,
        output FIFO_R_EN,
        output OUT_DATA,
        output OUT_NIBBLES,
        output OUT_VALID,
        output BUSY
    );

    // FIFO / downstream side.
    modport slave (
        output FIFO_DATA,
        output FIFO_EMPTY,
        output FLUSH,
        output OUT_READY,
        input  FIFO_R_EN,
        input  OUT_DATA,
        input  OUT_NIBBLES,
        input  OUT_VALID,
        input  BUSY
    );

endinterface

// File: rtl/pack_out_slot.sv
// Single output register with valid/ready hold; a load may coincide with an accept.
module pack_out_slot #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic [CNT_W-1:0]  i_cnt,
    input  logic              i_ready,
    output logic [WORD_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_cnt,
    output logic              o_valid,
    output logic              o_free_c
);

    logic [WORD_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;

    // Slot may take a new word when empty or when the current one leaves this cycle.
    assign o_free_c = !r_valid || i_ready;

    // Load replaces the held word without a bubble; accept alone empties the slot.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_data  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_cnt   <= i_cnt;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_cnt   = r_cnt;
    assign o_valid = r_valid;

endmodule

// File: rtl/fifo_nibble_packer.sv
// Drains asyn_fifo entries and packs PACK of them (first entry in LSBs) into one word.
module fifo_nibble_packer
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned PACK       = DEFAULT_PACK
) (
    input  logic                 R_CLK,
    input  logic                 RST_N,
    fifo_nibble_packer_if.master bus
);

    localparam int unsigned CNT_W  = cnt_width(PACK);
    localparam int unsigned WORD_W = DATA_WIDTH * PACK;
    localparam logic [CNT_W-1:0] PACK_CNT = CNT_W'(PACK);

    if (PACK < 2) begin : g_bad_pack
        $error("fifo_nibble_packer: PACK must be at least 2");
    end

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CNT_W-1:0]    r_issue_cnt;
    logic [CNT_W-1:0]    r_recv_cnt;
    logic [WORD_W-1:0]   r_asm;
    logic                r_flush_pending;

    logic                w_rd_en;
    logic                w_flush_drop;
    logic                w_in_flight;
    logic                w_landed;
    logic                w_complete;
    logic                w_flush_ready;
    logic                w_slot_free;
    logic                w_transfer;
    logic [WORD_W-1:0]   w_out_data;
    logic [CNT_W-1:0]    w_out_cnt;
    logic                w_out_valid;

    // At most one read is ever outstanding, so a count difference means data lands this cycle.
    assign w_in_flight   = (r_issue_cnt != r_recv_cnt);
    assign w_landed      = !w_in_flight;
    assign w_complete    = (r_recv_cnt == PACK_CNT);
    assign w_flush_ready = r_flush_pending && w_landed && (r_recv_cnt != '0);
    assign w_transfer    = (w_complete || w_flush_ready) && w_slot_free;

    // State register.
    always_ff @(posedge R_CLK) begin
        if (!RST_N) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL: begin
                if (w_transfer) begin
                    w_state_nxt = FILL;
                end else if (bus.FLUSH && !r_flush_pending) begin
                    w_state_nxt = FLUSHING;
                end else if (w_complete) begin
                    w_state_nxt = STALL;
                end
            end
            FLUSHING: begin
                if (w_transfer || w_flush_drop) begin
                    w_state_nxt = FILL;
                end
            end
            STALL: begin
                if (w_transfer) begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // State-dependent controls: read issue in FILL, empty-flush cancel in FLUSHING.
    always_comb begin
        w_rd_en      = 1'b0;
        w_flush_drop = 1'b0;
        case (r_state)
            FILL: begin
                w_rd_en = RST_N && !bus.FIFO_EMPTY && (r_issue_cnt < PACK_CNT)
                          && !r_flush_pending;
            end
            FLUSHING: begin
                w_flush_drop = w_landed && (r_recv_cnt == '0);
            end
            default: ;
        endcase
    end

    // Flush request latch; a transfer or an empty flush retires it, repeats are absorbed.
    always_ff @(posedge R_CLK) begin
        if (!RST_N) begin
            r_flush_pending <= 1'b0;
        end else if (w_transfer || w_flush_drop) begin
            r_flush_pending <= 1'b0;
        end else if (bus.FLUSH) begin
            r_flush_pending <= 1'b1;
        end
    end

    // Issue/receive counters and assembly register; cleared when the word moves out.
    always_ff @(posedge R_CLK) begin
        if (!RST_N) begin
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_asm       <= '0;
        end else if (w_transfer) begin
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_asm       <= '0;
        end else begin
            if (w_rd_en) begin
                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            end
            if (w_in_flight) begin
                for (int unsigned k = 0; k < PACK; k++) begin
                    if (r_recv_cnt == CNT_W'(k)) begin
                        r_asm[k*DATA_WIDTH +: DATA_WIDTH] <= bus.FIFO_DATA;
                    end
                end
                r_recv_cnt <= r_recv_cnt + CNT_W'(1);
            end
        end
    end

    pack_out_slot #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_slot (
        .i_clk    (R_CLK),
        .i_rst_n  (RST_N),
        .i_load   (w_transfer),
        .i_data   (r_asm),
        .i_cnt    (r_recv_cnt),
        .i_ready  (bus.OUT_READY),
        .o_data   (w_out_data),
        .o_cnt    (w_out_cnt),
        .o_valid  (w_out_valid),
        .o_free_c (w_slot_free)
    );

    assign bus.FIFO_R_EN   = w_rd_en;
    assign bus.OUT_DATA    = w_out_data;
    assign bus.OUT_NIBBLES = w_out_cnt;
    assign bus.OUT_VALID   = w_out_valid;
    assign bus.BUSY        = (r_recv_cnt != '0) || (r_issue_cnt != '0) || r_flush_pending;

endmodule
